// File: rtl/decode_issue_buffer.sv
// Fetch-to-decode instruction queue with valid/ready issue and flush on redirect.
// Define DECODE_SCOREBOARD_EN to include the pending-register issue block (RAW/WAW).
module decode_issue_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [31:0]      fetch_instruction,
  input  logic [31:0]      fetch_pc_plus_four,
  input  logic             flush,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [31:0]      issue_instruction,
  output logic [31:0]      issue_pc_plus_four,
  input  logic             issue_dest_valid,
  input  logic [4:0]       issue_dest_id,
  input  logic [4:0]       writeback_id,
  input  logic             reg_write_W,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             push, pop, blocked;

  assign head               = mem[rd_ptr];
  assign issue_instruction  = head.instr;
  assign issue_pc_plus_four = head.pc4;

  assign fetch_ready = (count != FULL_CNT) && !reset;
  assign issue_valid = (count != '0) && !flush && !blocked && !reset;
  assign push        = fetch_valid && fetch_ready && !flush;
  assign pop         = issue_valid && issue_ready;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= '{instr: fetch_instruction, pc4: fetch_pc_plus_four};
  end

`ifdef DECODE_SCOREBOARD_EN
  logic [31:1] pending;
  logic [31:0] pend_all;

  assign pend_all = {pending, 1'b0};
  assign blocked  = pend_all[head.instr[25:21]] || pend_all[head.instr[20:16]] ||
                    (issue_dest_valid && pend_all[issue_dest_id]);

  // Not cleared on flush: already-issued instructions still write back.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (pop && issue_dest_valid && issue_dest_id == 5'(r))
          pending[r] <= 1'b1;
        else if (reg_write_W && writeback_id == 5'(r))
          pending[r] <= 1'b0;
      end
    end
  end
`else
  logic unused_sb;
  assign unused_sb = ^{issue_dest_valid, issue_dest_id, writeback_id, reg_write_W};
  assign blocked   = 1'b0;
`endif

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Directed bench for decode_issue_buffer: queue model checked every cycle plus literal checks.
module tb_decode_issue_buffer;
  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic clock = 1'b0;
  logic reset, fetch_valid, flush, issue_ready, issue_dest_valid, reg_write_W;
  logic [31:0] fetch_instruction, fetch_pc_plus_four;
  logic [4:0]  issue_dest_id, writeback_id;
  logic fetch_ready, issue_valid;
  logic [31:0] issue_instruction, issue_pc_plus_four;
  logic [PTR_W:0] count;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;

  typedef struct {
    logic [31:0] i;
    logic [31:0] p;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] mpend;
  logic [31:0] dut_log[$];

  always #5 clock = ~clock;

  decode_issue_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instruction(fetch_instruction), .fetch_pc_plus_four(fetch_pc_plus_four),
    .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instruction(issue_instruction), .issue_pc_plus_four(issue_pc_plus_four),
    .issue_dest_valid(issue_dest_valid), .issue_dest_id(issue_dest_id),
    .writeback_id(writeback_id), .reg_write_W(reg_write_W),
    .count(count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: FIFO semantics with a register pending set, evaluated mid-cycle.
  always @(negedge clock) begin
    bit   efr, eiv, blk, fire;
    ent_t h;
    if (started) begin
      blk = 0;
      h   = '{32'h0, 32'h0};
      if (mq.size() != 0) h = mq[0];
`ifdef DECODE_SCOREBOARD_EN
      if (mq.size() != 0)
        blk = mpend[h.i[25:21]] || mpend[h.i[20:16]] || (issue_dest_valid && mpend[issue_dest_id]);
`endif
      efr  = (mq.size() != DEPTH) && !reset;
      eiv  = (mq.size() != 0) && !flush && !blk && !reset;
      fire = eiv && issue_ready;
      chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, efr});
      chk("issue_valid", {31'b0, issue_valid}, {31'b0, eiv});
      chk("count", 32'(count), mq.size());
      if (eiv) begin
        chk("issue_instruction", issue_instruction, h.i);
        chk("issue_pc_plus_four", issue_pc_plus_four, h.p);
      end
      if (issue_valid && issue_ready) dut_log.push_back(issue_instruction);
      if (reset) begin
        mq.delete();
        mpend = '0;
      end else begin
        if (reg_write_W && writeback_id != 0) mpend[writeback_id] = 1'b0;
        if (fire && issue_dest_valid && issue_dest_id != 0) mpend[issue_dest_id] = 1'b1;
        if (flush) mq.delete();
        else begin
          if (fire) void'(mq.pop_front());
          if (fetch_valid && efr) mq.push_back('{fetch_instruction, fetch_pc_plus_four});
        end
      end
    end
  end

  localparam logic [31:0] RAW_A = 32'h012A4021; // addu $8,$9,$10
  localparam logic [31:0] RAW_B = 32'h01095821; // addu $11,$8,$9
  localparam logic [31:0] COL_C = 32'h00222821; // addu $5,$1,$2
  localparam logic [31:0] COL_D = 32'h00A03021; // addu $6,$5,$0

  initial begin
    int hits;
    logic [31:0] w;
    mpend = '0;
    reset = 1; fetch_valid = 0; flush = 0; issue_ready = 0; issue_dest_valid = 0;
    reg_write_W = 0; fetch_instruction = 0; fetch_pc_plus_four = 0;
    issue_dest_id = 0; writeback_id = 0;
    tick();
    started = 1;
    tick();
    chk("rst_fetch_ready", {31'b0, fetch_ready}, 32'd0);
    chk("rst_issue_valid", {31'b0, issue_valid}, 32'd0);
    reset = 0;
    #1;
    chk("post_rst_fetch_ready", {31'b0, fetch_ready}, 32'd1);
    chk("post_rst_issue_valid", {31'b0, issue_valid}, 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);

    // fill with issue stalled
    issue_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      fetch_valid = 1; fetch_instruction = i; fetch_pc_plus_four = 32'(i * 4 + 4);
      tick();
    end
    fetch_valid = 0;
    #1;
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_fetch_ready", {31'b0, fetch_ready}, 32'd0);
    chk("fill_head", issue_instruction, 32'h1);
    chk("fill_head_pc", issue_pc_plus_four, 32'h8);

    // reset mid-operation with push and pop requested
    fetch_valid = 1; fetch_instruction = 32'h77; issue_ready = 1; reset = 1;
    tick();
    reset = 0; fetch_valid = 0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_issue_valid", {31'b0, issue_valid}, 32'd0);

    // drain at full throughput across the pointer wrap
    dut_log.delete();
    issue_ready = 1;
    for (int i = 1; i <= 6; i++) begin
      fetch_valid = 1; fetch_instruction = i; fetch_pc_plus_four = 32'(i * 4 + 4);
      tick();
      chk("drain_count_le1", {31'b0, (count <= 1)}, 32'd1);
    end
    fetch_valid = 0;
    tick(); tick();
    chk("drain_issued", dut_log.size(), 32'd6);
    for (int i = 0; i < 6 && i < dut_log.size(); i++) chk("drain_order", dut_log[i], 32'(i + 1));

    // flush with a simultaneous push
    dut_log.delete();
    issue_ready = 0;
    for (int i = 1; i <= 3; i++) begin
      fetch_valid = 1; fetch_instruction = 32'(i * 32'h11);
      tick();
    end
    chk("preflush_count", 32'(count), 32'd3);
    fetch_instruction = 32'h99; flush = 1;
    tick();
    flush = 0; fetch_valid = 0;
    #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_issue_valid", {31'b0, issue_valid}, 32'd0);
    issue_ready = 1;
    tick(); tick();
    hits = 0;
    foreach (dut_log[k]) if (dut_log[k] == 32'h99) hits++;
    chk("flush_discard", hits, 32'd0);
    chk("flush_issued_none", dut_log.size(), 32'd0);

    // RAW: B reads $8 written by A
    dut_log.delete();
    issue_ready = 1;
    fetch_valid = 1; fetch_instruction = RAW_A; fetch_pc_plus_four = 32'h100;
    tick();
    fetch_instruction = RAW_B; fetch_pc_plus_four = 32'h104;
    issue_dest_valid = 1; issue_dest_id = 5'd8;
    tick();
    fetch_valid = 0; issue_dest_id = 5'd11;
    #1;
`ifdef DECODE_SCOREBOARD_EN
    for (int c = 0; c < 3; c++) begin
      chk("raw_blocked", {31'b0, issue_valid}, 32'd0);
      tick();
    end
    writeback_id = 5'd8; reg_write_W = 1;
    #1;
    chk("raw_no_wb_bypass", {31'b0, issue_valid}, 32'd0);
    tick();
    reg_write_W = 0; writeback_id = 0;
    #1;
    chk("raw_unblocked", {31'b0, issue_valid}, 32'd1);
    tick();
`else
    chk("raw_back_to_back", {31'b0, issue_valid}, 32'd1);
    tick();
`endif
    issue_dest_valid = 0;
    w = (dut_log.size() >= 2) ? dut_log[1] : 32'h0;
    chk("raw_second", w, RAW_B);
    writeback_id = 5'd11; reg_write_W = 1;
    tick();
    reg_write_W = 0; writeback_id = 0;

    // set/clear collision on $5
    fetch_valid = 1; fetch_instruction = COL_C; fetch_pc_plus_four = 32'h200;
    tick();
    fetch_instruction = COL_D; fetch_pc_plus_four = 32'h204;
    issue_dest_valid = 1; issue_dest_id = 5'd5; writeback_id = 5'd5; reg_write_W = 1;
    tick();
    fetch_valid = 0; reg_write_W = 0; writeback_id = 0; issue_dest_id = 5'd6;
    #1;
`ifdef DECODE_SCOREBOARD_EN
    chk("collision_set_wins", {31'b0, issue_valid}, 32'd0);
    tick();
    chk("collision_still_blocked", {31'b0, issue_valid}, 32'd0);
    writeback_id = 5'd5; reg_write_W = 1;
    tick();
    reg_write_W = 0; writeback_id = 0;
    #1;
    chk("collision_released", {31'b0, issue_valid}, 32'd1);
    tick();
`else
    chk("collision_ignored", {31'b0, issue_valid}, 32'd1);
    tick();
`endif
    issue_dest_valid = 0;
    writeback_id = 5'd6; reg_write_W = 1;
    tick();
    reg_write_W = 0; writeback_id = 0;
    tick(); tick();
    chk("end_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
